// File: rtl/snn_step_controller.sv
// SNN time-step controller: synchronises the SPI-domain ready flags, generates
// the periodic step strobe from the latched divider and hands one captured
// spike vector to the network per step.
module snn_step_controller #(
  parameter int DIV_W   = 8,
  parameter int SPIKE_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_div_ready,
  input  logic               input_spike_ready,
  input  logic [DIV_W-1:0]   div_value,
  input  logic [SPIKE_W-1:0] spike_in,
  output logic               step_pulse,
  output logic [SPIKE_W-1:0] spikes_out,
  output logic               spikes_valid,
  output logic               running,
  output logic [CNT_W-1:0]   step_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e             state_q;
  logic [2:0]         div_sync_q;   // [0]=s1, [1]=s2, [2]=s3
  logic [2:0]         spk_sync_q;
  logic [DIV_W-1:0]   div_reg_q;
  logic [DIV_W-1:0]   cnt_q;
  logic               step_pulse_q;
  logic               running_q;
  logic [CNT_W-1:0]   step_count_q;
  logic               pending_q;
  logic [SPIKE_W-1:0] pending_vec_q;
  logic [SPIKE_W-1:0] spikes_out_q;
  logic               spikes_valid_q;

  logic div_rise, div_fall, spk_rise, step_d;

  // Edge detect on the synchronised levels (s2 vs s3).
  assign div_rise = div_sync_q[1] & ~div_sync_q[2];
  assign div_fall = ~div_sync_q[1] & div_sync_q[2];
  assign spk_rise = spk_sync_q[1] & ~spk_sync_q[2];

  // A step fires when the period counter wraps in RUN; a stop request wins.
  assign step_d = (state_q == RUN) && !div_fall && (cnt_q == div_reg_q);

  // Three-flop synchronisers for both asynchronous ready levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_sync_q <= '0;
      spk_sync_q <= '0;
    end else begin
      div_sync_q <= {div_sync_q[1:0], clk_div_ready};
      spk_sync_q <= {spk_sync_q[1:0], input_spike_ready};
    end
  end

  // Control FSM with registered step strobe, running flag and step counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_reg_q    <= '0;
      cnt_q        <= '0;
      step_pulse_q <= 1'b0;
      running_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      step_pulse_q <= step_d;
      if (step_d) step_count_q <= step_count_q + 1'b1;
      case (state_q)
        IDLE: begin
          running_q <= 1'b0;
          if (div_rise) begin
            state_q      <= LOAD;
            div_reg_q    <= div_value;
            cnt_q        <= '0;
            step_count_q <= '0;
          end
        end
        LOAD: begin
          if (div_fall) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end else begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (div_fall) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q == div_reg_q) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Spike capture and hand-off: a step consumes the vector pending before the
  // edge, so a capture on the same edge becomes pending for the next step.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= 1'b0;
      pending_vec_q  <= '0;
      spikes_out_q   <= '0;
      spikes_valid_q <= 1'b0;
    end else begin
      spikes_valid_q <= 1'b0;
      if (step_d) begin
        spikes_out_q   <= pending_q ? pending_vec_q : '0;
        spikes_valid_q <= pending_q;
        pending_q      <= 1'b0;
      end
      if (spk_rise) begin
        pending_vec_q <= spike_in;
        pending_q     <= 1'b1;
      end
    end
  end

  assign step_pulse   = step_pulse_q;
  assign spikes_out   = spikes_out_q;
  assign spikes_valid = spikes_valid_q;
  assign running      = running_q;
  assign step_count   = step_count_q;

endmodule

// File: tb/tb_snn_step_controller.sv
// Self-checking bench for snn_step_controller: table-driven timing vectors
// plus a spike scoreboard popped on every observed step strobe.
module tb_snn_step_controller;

  localparam int DIV_W   = 8;
  localparam int SPIKE_W = 8;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_div_ready;
  logic               input_spike_ready;
  logic [DIV_W-1:0]   div_value;
  logic [SPIKE_W-1:0] spike_in;
  logic               step_pulse;
  logic [SPIKE_W-1:0] spikes_out;
  logic               spikes_valid;
  logic               running;
  logic [CNT_W-1:0]   step_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [SPIKE_W-1:0] vec;
    logic               vld;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [DIV_W-1:0] div;
    int               first;   // ticks from raising ready to first strobe
    int               period;
  } vec_t;
  vec_t tbl[5];

  snn_step_controller #(.DIV_W(DIV_W), .SPIKE_W(SPIKE_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .clk_div_ready     (clk_div_ready),
    .input_spike_ready (input_spike_ready),
    .div_value         (div_value),
    .spike_in          (spike_in),
    .step_pulse        (step_pulse),
    .spikes_out        (spikes_out),
    .spikes_valid      (spikes_valid),
    .running           (running),
    .step_count        (step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SPIKE_W-1:0] v, input logic vl);
    sb_t e;
    e.vec = v;
    e.vld = vl;
    sb_q.push_back(e);
  endtask

  // Advance at least one cycle, stop on the next strobe (bounded).
  task automatic wait_pulse(output int n);
    logic bad;
    n   = 0;
    bad = 1'b0;
    do begin
      tick();
      n++;
      if (!step_pulse && spikes_valid) bad = 1'b1;
    end while (!step_pulse && n < 600);
    chk("valid_without_step", {31'd0, bad}, 32'd0);
    chk("pulse_seen", {31'd0, step_pulse}, 32'd1);
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=step expected=none");
    end else begin
      e = sb_q.pop_front();
      chk("sb_step_pulse", {31'd0, step_pulse}, 32'd1);
      chk("sb_spikes_out", {24'd0, spikes_out}, {24'd0, e.vec});
      chk("sb_spikes_valid", {31'd0, spikes_valid}, {31'd0, e.vld});
    end
  endtask

  task automatic drain(input int cnt);
    int n;
    for (int k = 0; k < cnt; k++) begin
      wait_pulse(n);
      pop_check();
    end
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    clk_div_ready     = 1'b0;
    input_spike_ready = 1'b0;
    div_value         = '0;
    spike_in          = '0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int  n;
    logic bad;

    tbl[0] = '{8'd3,   8,   4};
    tbl[1] = '{8'd0,   5,   1};
    tbl[2] = '{8'd2,   7,   3};
    tbl[3] = '{8'd5,   10,  6};
    tbl[4] = '{8'd255, 260, 256};

    // Reset and idle with both flags low.
    do_reset();
    repeat (20) tick();
    chk("rst_step_pulse", {31'd0, step_pulse}, 32'd0);
    chk("rst_spikes_out", {24'd0, spikes_out}, 32'd0);
    chk("rst_spikes_valid", {31'd0, spikes_valid}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_step_count", {16'd0, step_count}, 32'd0);

    // Divider timing vectors; div_value is scrambled after the load edge.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      div_value     = tbl[i].div;
      clk_div_ready = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
        if (n == 3) begin
          chk("running_in_load", {31'd0, running}, 32'd0);
          div_value = ~tbl[i].div;
        end
        if (n == 4) chk("running_from_e3", {31'd0, running}, 32'd1);
      end while (!step_pulse && n < 600);
      chk("first_step_latency", n, tbl[i].first);
      chk("step_count_first", {16'd0, step_count}, 32'd1);
      chk("first_step_no_spike", {31'd0, spikes_valid}, 32'd0);
      for (int k = 2; k <= 3; k++) begin
        wait_pulse(n);
        chk("step_period", n, tbl[i].period);
        chk("step_count_inc", {16'd0, step_count}, k);
      end
    end

    // Spike path, divider 2 (period 3).
    do_reset();
    div_value     = 8'd2;
    clk_div_ready = 1'b1;
    push(8'h00, 1'b0);
    drain(1);                                  // P0
    tick();                                    // P0+1
    spike_in          = 8'hA5;
    input_spike_ready = 1'b1;                  // captured at P0+4
    push(8'h00, 1'b0);                         // P0+3
    push(8'hA5, 1'b1);                         // P0+6
    drain(2);
    // Capture 0x11 at P0+10, then 0x22 on the step edge P0+12.
    input_spike_ready = 1'b0;
    tick();                                    // P0+7
    input_spike_ready = 1'b1;
    spike_in          = 8'h11;
    tick();                                    // P0+8
    input_spike_ready = 1'b0;
    tick();                                    // P0+9 step
    push(8'h00, 1'b0);
    pop_check();
    input_spike_ready = 1'b1;
    tick();                                    // P0+10
    spike_in = 8'h22;
    tick();                                    // P0+11
    tick();                                    // P0+12 step
    push(8'h11, 1'b1);
    pop_check();
    tick();                                    // P0+13
    chk("spikes_out_hold", {24'd0, spikes_out}, 32'h11);
    chk("valid_low_between", {31'd0, spikes_valid}, 32'd0);
    push(8'h22, 1'b1);                         // P0+15
    push(8'h00, 1'b0);                         // P0+18
    drain(2);
    input_spike_ready = 1'b0;

    // Stop mid-period, divider 3.
    do_reset();
    div_value     = 8'd3;
    clk_div_ready = 1'b1;
    push(8'h00, 1'b0);
    drain(1);                                  // P
    clk_div_ready = 1'b0;
    tick();                                    // P+1
    tick();                                    // P+2
    chk("running_before_stop", {31'd0, running}, 32'd1);
    tick();                                    // P+3 -> IDLE
    chk("stop_running", {31'd0, running}, 32'd0);
    chk("stop_step_pulse", {31'd0, step_pulse}, 32'd0);
    chk("stop_step_count", {16'd0, step_count}, 32'd1);
    bad = 1'b0;
    repeat (12) begin
      tick();
      if (step_pulse || running) bad = 1'b1;
    end
    chk("idle_quiet", {31'd0, bad}, 32'd0);
    chk("idle_count_held", {16'd0, step_count}, 32'd1);

    // Reset mid-RUN with a vector still pending.
    do_reset();
    div_value     = 8'd2;
    clk_div_ready = 1'b1;
    push(8'h00, 1'b0);
    drain(1);                                  // P
    tick();                                    // P+1
    spike_in          = 8'h5A;
    input_spike_ready = 1'b1;
    tick();                                    // P+2
    input_spike_ready = 1'b0;
    tick();                                    // P+3 step
    push(8'h00, 1'b0);
    pop_check();
    input_spike_ready = 1'b1;
    tick();                                    // P+4 capture 0x5A
    spike_in = 8'h3C;
    tick();                                    // P+5
    tick();                                    // P+6 step, 0x3C now pending
    push(8'h5A, 1'b1);
    pop_check();
    reset             = 1'b1;
    input_spike_ready = 1'b0;
    clk_div_ready     = 1'b0;
    tick();
    chk("mid_rst_step_pulse", {31'd0, step_pulse}, 32'd0);
    chk("mid_rst_spikes_out", {24'd0, spikes_out}, 32'd0);
    chk("mid_rst_spikes_valid", {31'd0, spikes_valid}, 32'd0);
    chk("mid_rst_running", {31'd0, running}, 32'd0);
    chk("mid_rst_step_count", {16'd0, step_count}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    clk_div_ready = 1'b1;
    push(8'h00, 1'b0);                         // pending was discarded
    drain(1);
    chk("restart_step_count", {16'd0, step_count}, 32'd1);

    chk("sb_leftover", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_step_controller.md
Name: snn_step_controller

Overview:
- Sits directly downstream of the SPI configuration interface, in the core's system clock domain.
- Synchronises the SPI-domain ready flags `clk_div_ready` and `input_spike_ready`, and latches the clock-divider byte and input-spike byte from the configuration memory image.
- Generates the periodic SNN time-step strobe.
- Presents one spike vector per time step to the network.

Parameters:
- DIV_W, 8, width of divider value and internal step counter.
- SPIKE_W, 8, width of input spike vector.
- CNT_W, 16, width of time-step counter.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- clk_div_ready  input  1  asynchronous level from SPI domain; high = divider configured, run.
- input_spike_ready  input  1  asynchronous level from SPI domain; each rising edge = new spike vector available.
- div_value  input  DIV_W  divider byte from config memory; quasi-static.
- spike_in  input  SPIKE_W  spike byte from config memory; quasi-static.
- step_pulse  output  1  one-cycle time-step strobe.
- spikes_out  output  SPIKE_W  spike vector for the current step.
- spikes_valid  output  1  high in the same cycle as step_pulse when spikes_out holds a freshly loaded vector.
- running  output  1  high while in RUN.
- step_count  output  CNT_W  number of steps since last LOAD.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (ports clk, reset).
  - While reset is high at a clk edge, all registers clear: state=IDLE, all synchroniser flops=0, div_reg=0, cnt=0, pending=0, pending_vec=0.
  - Outputs after reset: step_pulse=0, spikes_out=0, spikes_valid=0, running=0, step_count=0.
  - Reset mid-RUN discards any pending spike vector.
- Synchronisers:
  - Each ready flag passes through a 3-flop chain s1 -> s2 -> s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An input change sampled by s1 at edge E0 produces rise/fall during the cycle after E1.
- FSM states and transitions (IDLE, LOAD, RUN):
  - IDLE: on clk_div rise, go to LOAD at next edge (E2); at that edge div_reg<=div_value, cnt<=0, step_count<=0.
  - LOAD: one cycle; running=0; go to RUN unconditionally unless clk_div fall is active, in which case go to IDLE.
  - RUN: running=1 (registered, visible from edge E3).
    - Each edge: if cnt==div_reg then cnt<=0 and step_pulse<=1; else cnt<=cnt+1 and step_pulse<=0.
    - Step period = div_reg+1 cycles; div_reg=0 gives step_pulse high every cycle.
    - First step_pulse is high after the (div_reg+1)th edge counted from RUN entry.
    - On clk_div fall: go to IDLE next edge; cnt<=0, step_pulse<=0.
  - clk_div rise outside IDLE is ignored.
  - div_value changes outside the IDLE->LOAD edge are ignored.
- Spike path:
  - On input_spike rise, in any state: pending_vec<=spike_in, pending<=1.
  - On each edge that sets step_pulse<=1:
    - If pending: spikes_out<=pending_vec, spikes_valid<=1.
    - Else: spikes_out<=0, spikes_valid<=0.
    - pending<=0 in both cases.
  - Simultaneous capture and step at the same edge: the step consumes the old pending_vec (or zero if none). The new spike_in becomes pending for the next step, with pending=1.
  - spikes_valid is low in every cycle where step_pulse is low.
  - spikes_out holds its value between steps.
- step_count:
  - Increments on each edge that sets step_pulse<=1.
  - Wraps 2^CNT_W-1 -> 0.
  - Cleared on entry to LOAD; holds its value in IDLE.

Test Plan:
- Reset, then hold both flags low for 20 cycles -> all outputs 0, running=0.
- div_value=3, raise clk_div_ready sampled at E0 -> running=1 from E3. step_pulse is high after E7, E11, E15 (period 4). step_count reads 1, 2, 3.
- div_value=0 in RUN -> step_pulse high every cycle; step_count increments by 1 per cycle.
- div_value=2 in RUN; spike_in=0xA5 with input_spike_ready rise -> next step_pulse has spikes_out=0xA5, spikes_valid=1. The following step has spikes_out=0x00, spikes_valid=0.
- Spike capture timed to coincide with a step edge: pending 0x11 and new spike_in 0x22 -> that step outputs 0x11; the next step outputs 0x22 with valid=1.
- clk_div_ready falls mid-period (cnt=1) -> IDLE 3 edges later; step_pulse=0, running=0, step_count held.
  - Assert reset during RUN -> all outputs 0 after that edge; pending cleared, so the next RUN's first step has spikes_valid=0.
